// File: rtl/stepper_full_step_drv_pkg.sv
// Package stepper_pkg: FSM state encoding and the full-step coil pattern table
// shared by the stepper full-step driver and its bench-facing interface.
package stepper_pkg;

  // Two-state move controller
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Two-phase-on coil patterns {A,B,A',B'} indexed by the 2-bit phase
  localparam logic [3:0] PHASE_PATTERN [0:3] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

  // Look up the coil pattern for a phase index
  function automatic logic [3:0] phase_pattern(input logic [1:0] ph);
    return PHASE_PATTERN[ph];
  endfunction

endpackage

// File: rtl/stepper_full_step_drv_if.sv
// Move-command handshake between the command logic (master) and the
// stepper driver (slave). cmd_ready is driven by the driver.
interface stepper_full_step_drv_if #(
  parameter int STEP_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic              abort;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, abort,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_full_step_drv_step_tick_detect.sv
// step_tick_detect: registers the divided step clock and produces a one-cycle
// tick on each rising edge. The history register resets to 1 so a step clock
// that is already high when reset releases does not look like a new edge.
module step_tick_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_step_clk,
  output logic o_tick
);
  logic r_step_clk_q;

  // Previous-cycle copy of the step clock, reset high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step_clk_q <= 1'b1;
    end else begin
      r_step_clk_q <= i_step_clk;
    end
  end

  assign o_tick = i_step_clk & ~r_step_clk_q;
endmodule

// File: rtl/stepper_full_step_drv.sv
// stepper_full_step_drv: turns move commands into a two-phase-on full-step
// coil sequence, one step per rising edge of the divided step clock.
// Optional feature macro: HOLD_TORQUE_EN (keep the last coil pattern energised
// in IDLE); when undefined the coils are released to 0000 in IDLE.
module stepper_full_step_drv
  import stepper_pkg::*;
#(
  parameter int STEP_W = 16,
  parameter int POS_W  = 24
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_step_clk,
  stepper_full_step_drv_if.slave cmd,
  output logic [3:0]           o_coil,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [POS_W-1:0]     o_pos
);
  localparam logic [STEP_W-1:0] STEPS_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEPS_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]  POS_PLUS1  = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]  POS_MINUS1 = {POS_W{1'b1}};

  state_e            r_state;
  logic [1:0]        r_phase;
  logic [3:0]        r_coil;
  logic [POS_W-1:0]  r_pos;
  logic [STEP_W-1:0] r_remaining;
  logic              r_dir;
  logic              r_busy;
  logic              r_done;
  logic              r_ready;

  logic              w_tick;
  logic [1:0]        w_next_phase;
  logic [POS_W-1:0]  w_next_pos;
  logic [3:0]        w_end_coil;
  logic [3:0]        w_abort_coil;

  step_tick_detect u_tick (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_step_clk (i_step_clk),
    .o_tick     (w_tick)
  );

  // Next phase and position for a step in the latched direction
  always_comb begin
    w_next_phase = r_phase;
    w_next_pos   = r_pos;
    if (r_dir) begin
      w_next_phase = r_phase + 2'd1;
      w_next_pos   = r_pos + POS_PLUS1;
    end else begin
      w_next_phase = r_phase - 2'd1;
      w_next_pos   = r_pos + POS_MINUS1;
    end
  end

`ifdef HOLD_TORQUE_EN
  // Holding torque: park on the pattern the motor is sitting at
  assign w_end_coil   = phase_pattern(w_next_phase);
  assign w_abort_coil = r_coil;
`else
  // Coils released whenever the driver returns to IDLE
  assign w_end_coil   = 4'b0000;
  assign w_abort_coil = 4'b0000;
`endif

  // Move FSM with step counter, position counter and registered coil drive
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= 2'd0;
      r_coil      <= 4'b0000;
      r_pos       <= {POS_W{1'b0}};
      r_remaining <= STEPS_ZERO;
      r_dir       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd.cmd_valid && r_ready) begin
            if (cmd.cmd_steps == STEPS_ZERO) begin
              r_done <= 1'b1;
            end else begin
              // Energise the current phase before the first step
              r_coil      <= phase_pattern(r_phase);
              r_remaining <= cmd.cmd_steps;
              r_dir       <= cmd.cmd_dir;
              r_busy      <= 1'b1;
              r_ready     <= 1'b0;
              r_state     <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (cmd.abort) begin
            // Abort takes priority over a coincident tick: no step this cycle
            r_coil  <= w_abort_coil;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_phase <= w_next_phase;
            r_pos   <= w_next_pos;
            if (r_remaining != STEPS_ZERO) begin
              r_remaining <= r_remaining - STEPS_ONE;
            end
            if (r_remaining <= STEPS_ONE) begin
              r_coil  <= w_end_coil;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_coil <= phase_pattern(w_next_phase);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_coil  <= 4'b0000;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = r_ready;
  assign o_coil        = r_coil;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_pos         = r_pos;
endmodule

// File: tb/tb_stepper_full_step_drv.sv
// Bench for stepper_full_step_drv: a table of move commands driven through a
// cycle-level reference model; the model's expected outputs go into a queue
// and are popped and compared one cycle later against the DUT.
`timescale 1ns/1ps
module tb_stepper_full_step_drv;
  localparam int STEP_W = 16;
  localparam int POS_W  = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step_clk = 1'b1;
  logic [3:0] coil;
  logic busy, done;
  logic [POS_W-1:0] pos;

  always #10 clk = ~clk;

  stepper_full_step_drv_if #(.STEP_W(STEP_W)) cmd_if ();

  stepper_full_step_drv #(.STEP_W(STEP_W), .POS_W(POS_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_step_clk (step_clk),
    .cmd        (cmd_if),
    .o_coil     (coil),
    .o_busy     (busy),
    .o_done     (done),
    .o_pos      (pos)
  );

  typedef struct packed {
    logic [3:0]       coil;
    logic [POS_W-1:0] pos;
    logic             busy;
    logic             done;
    logic             ready;
  } obs_t;

  typedef struct {
    logic             dir;
    int               steps;
    int               abort_tick;
    bit               do_reset;
    logic [POS_W-1:0] exp_pos;
  } vec_t;

  obs_t sb_q[$];
  vec_t vecs[8];
  logic [3:0] pat [4];

  int n_vec = 0;
  int n_err = 0;

  int               m_phase;
  logic [POS_W-1:0] m_pos;
  logic [3:0]       m_coil;
  int               m_rem;
  logic             m_dir;
  logic             m_busy;
  logic             m_ready;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input logic d);
    obs_t e;
    e = {m_coil, m_pos, m_busy, d, m_ready};
    sb_q.push_back(e);
  endtask

  task automatic check_out(input string name);
    obs_t a, e;
    a = {coil, pos, busy, done, cmd_if.cmd_ready};
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      e = sb_q.pop_front();
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got coil=%b pos=%h busy=%b done=%b ready=%b, want coil=%b pos=%h busy=%b done=%b ready=%b",
                 name, a.coil, a.pos, a.busy, a.done, a.ready, e.coil, e.pos, e.busy, e.done, e.ready);
      end
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pos   = '0;
    m_coil  = 4'b0000;
    m_rem   = 0;
    m_dir   = 1'b0;
    m_busy  = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_clk = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir = 1'b0;
    cmd_if.cmd_steps = 16'd0;
    cmd_if.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    push_model(1'b0);
    check_out("reset");
    rst = 1'b0;
    cyc();
    push_model(1'b0);
    check_out("reset_release");
    step_clk = 1'b0;
    cyc();
    push_model(1'b0);
    check_out("idle_after_reset");
  endtask

  task automatic accept(input logic dir, input int steps);
    int k;
    k = 0;
    while (cmd_if.cmd_ready !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    if (cmd_if.cmd_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got ready=%b, want 1", cmd_if.cmd_ready);
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir = dir;
    cmd_if.cmd_steps = 16'(steps);
    if (steps == 0) begin
      push_model(1'b1);
    end else begin
      m_coil  = pat[m_phase];
      m_busy  = 1'b1;
      m_ready = 1'b0;
      m_rem   = steps;
      m_dir   = dir;
      push_model(1'b0);
    end
    cyc();
    cmd_if.cmd_valid = 1'b0;
    check_out(steps == 0 ? "accept_zero" : "accept_energise");
    if (steps == 0) begin
      cyc();
      push_model(1'b0);
      check_out("zero_done_clear");
    end
  endtask

  task automatic tick(input logic abort_now);
    step_clk = 1'b1;
    cmd_if.abort = abort_now;
    if (m_busy && abort_now) begin
      m_busy  = 1'b0;
      m_ready = 1'b1;
`ifndef HOLD_TORQUE_EN
      m_coil  = 4'b0000;
`endif
      push_model(1'b1);
    end else if (m_busy) begin
      m_phase = m_dir ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
      m_pos   = m_dir ? m_pos + 24'd1 : m_pos - 24'd1;
      m_rem   = m_rem - 1;
      if (m_rem == 0) begin
        m_busy  = 1'b0;
        m_ready = 1'b1;
`ifdef HOLD_TORQUE_EN
        m_coil  = pat[m_phase];
`else
        m_coil  = 4'b0000;
`endif
        push_model(1'b1);
      end else begin
        m_coil = pat[m_phase];
        push_model(1'b0);
      end
    end else begin
      push_model(1'b0);
    end
    cyc();
    step_clk = 1'b0;
    cmd_if.abort = 1'b0;
    check_out(abort_now ? "tick_abort" : "tick");
    cyc();
    push_model(1'b0);
    check_out("tick_gap");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pat[0] = 4'b1100;
    pat[1] = 4'b0110;
    pat[2] = 4'b0011;
    pat[3] = 4'b1001;

    //          dir   steps abort reset exp_pos
    vecs[0] = '{1'b1, 4, 0, 1'b1, 24'h000004};
    vecs[1] = '{1'b0, 3, 0, 1'b1, 24'hFFFFFD};
    vecs[2] = '{1'b1, 0, 0, 1'b1, 24'h000000};
    vecs[3] = '{1'b1, 5, 2, 1'b1, 24'h000001};
    vecs[4] = '{1'b1, 1, 0, 1'b1, 24'h000001};
    vecs[5] = '{1'b0, 6, 0, 1'b1, 24'hFFFFFA};
    vecs[6] = '{1'b1, 2, 0, 1'b0, 24'hFFFFFC};
    vecs[7] = '{1'b0, 0, 0, 1'b0, 24'hFFFFFC};

    model_reset();
    for (int i = 0; i < 8; i++) begin
      int t;
      if (vecs[i].do_reset) do_reset();
      accept(vecs[i].dir, vecs[i].steps);
      t = 1;
      while (m_busy && t <= vecs[i].steps) begin
        tick(t == vecs[i].abort_tick);
        t++;
      end
      n_vec++;
      if (pos !== vecs[i].exp_pos) begin
        n_err++;
        $display("FAIL vec%0d_final_pos: got %h, want %h", i, pos, vecs[i].exp_pos);
      end
    end

    // A command presented during RUN must be held off and not reload the count
    do_reset();
    accept(1'b1, 2);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_steps = 16'd9;
    cmd_if.cmd_dir = 1'b0;
    push_model(1'b0);
    cyc();
    check_out("cmd_held_off_in_run");
    cmd_if.cmd_valid = 1'b0;
    tick(1'b0);
    tick(1'b0);

    // Abort and ticks while IDLE do nothing
    cmd_if.abort = 1'b1;
    push_model(1'b0);
    cyc();
    cmd_if.abort = 1'b0;
    check_out("abort_in_idle");
    cyc();
    push_model(1'b0);
    check_out("abort_in_idle_after");
    tick(1'b0);

    // Reset in the middle of a move clears everything including the coils
    accept(1'b1, 5);
    tick(1'b0);
    rst = 1'b1;
    model_reset();
    push_model(1'b0);
    cyc();
    check_out("reset_mid_move");
    rst = 1'b0;
    cyc();
    push_model(1'b0);
    check_out("reset_mid_move_release");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
